// File: rtl/snurisc_trace_checker.sv
// Run controller and in-order commit-trace checker for the snurisc bench.
// Loads an expected trace, gates the core clock enable, and reports pass/fail.
module snurisc_trace_checker #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CYCW    = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ld_we,
  input  logic [AW-1:0]   i_ld_addr,
  input  logic [XLEN-1:0] i_ld_pc,
  input  logic [XLEN-1:0] i_ld_wdata,
  input  logic [4:0]      i_ld_rd,
  input  logic            i_ld_wen,
  input  logic [AW:0]     i_len,
  input  logic            i_start,
  input  logic            i_clear,
  input  logic            i_cm_valid,
  input  logic [XLEN-1:0] i_cm_pc,
  input  logic [XLEN-1:0] i_cm_wdata,
  input  logic [4:0]      i_cm_rd,
  input  logic            i_cm_wen,
  output logic            o_core_en,
  output logic            o_busy,
  output logic            o_pass,
  output logic            o_fail,
  output logic [2:0]      o_err_code,
  output logic [AW:0]     o_err_idx,
  output logic [CYCW-1:0] o_cycles
);

  localparam int unsigned EW = 2 * XLEN + 6;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PC    = 3'd1;
  localparam logic [2:0] E_RD    = 3'd2;
  localparam logic [2:0] E_WDATA = 3'd3;
  localparam logic [2:0] E_TMO   = 3'd4;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   entry;
  logic [XLEN-1:0] exp_pc, exp_wdata;
  logic [4:0]      exp_rd;
  logic            exp_wen;
  logic [2:0]      cmp_code;

  logic [1:0]      state_q, state_d;
  logic [AW:0]     idx_q, idx_d;
  logic [AW:0]     len_q, len_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic [2:0]      code_q, code_d;
  logic [AW:0]     eidx_q, eidx_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            core_en_q, core_en_d;

  // Trace store: loaded only while idle, never reset.
  always_ff @(posedge i_clk) begin
    if (i_ld_we && state_q == S_IDLE) begin
      mem[i_ld_addr] <= {i_ld_pc, i_ld_rd, i_ld_wen, i_ld_wdata};
    end
  end

  assign entry     = mem[idx_q[AW-1:0]];
  assign exp_pc    = entry[EW-1 -: XLEN];
  assign exp_rd    = entry[XLEN+5:XLEN+1];
  assign exp_wen   = entry[XLEN];
  assign exp_wdata = entry[XLEN-1:0];

  // Prioritised commit compare; rd/wdata ignored when no write is expected.
  always_comb begin
    cmp_code = E_NONE;
    if (i_cm_pc != exp_pc) begin
      cmp_code = E_PC;
    end else if ((i_cm_wen != exp_wen) || (exp_wen && (i_cm_rd != exp_rd))) begin
      cmp_code = E_RD;
    end else if (exp_wen && (i_cm_wdata != exp_wdata)) begin
      cmp_code = E_WDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d  = i_len;
          idx_d  = '0;
          tmo_d  = '0;
          cyc_d  = '0;
          code_d = E_NONE;
          eidx_d = '0;
          if (i_len == '0) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cyc_q != {CYCW{1'b1}}) cyc_d = cyc_q + CYCW'(1);
        tmo_d = tmo_q + TW'(1);
        if (i_cm_valid) begin
          tmo_d = '0;
          if (cmp_code != E_NONE) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            code_d  = cmp_code;
            eidx_d  = idx_q;
          end else begin
            idx_d = idx_q + (AW+1)'(1);
            if (idx_q + (AW+1)'(1) == len_q) begin
              state_d = S_PASS;
              pass_d  = 1'b1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          code_d  = E_TMO;
          eidx_d  = idx_q;
        end
      end
      S_PASS, S_FAIL: begin
        if (i_clear) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    core_en_d = (state_d == S_RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      cyc_q     <= '0;
      code_q    <= E_NONE;
      eidx_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      core_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      cyc_q     <= cyc_d;
      code_q    <= code_d;
      eidx_q    <= eidx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      core_en_q <= core_en_d;
    end
  end

  assign o_core_en  = core_en_q;
  assign o_busy     = core_en_q;
  assign o_pass     = pass_q;
  assign o_fail     = fail_q;
  assign o_err_code = code_q;
  assign o_err_idx  = eidx_q;
  assign o_cycles   = cyc_q;

endmodule

// File: tb/tb_snurisc_trace_checker.sv
// Bench for snurisc_trace_checker: compare-rule table, directed corner sequences,
// and randomized runs against a commit-by-commit reference model.
module tb_snurisc_trace_checker;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned TMO   = 16;
  localparam int unsigned CYCW  = 6;

  logic            clk, rst_n;
  logic            ld_we;
  logic [AW-1:0]   ld_addr;
  logic [XLEN-1:0] ld_pc, ld_wdata;
  logic [4:0]      ld_rd;
  logic            ld_wen;
  logic [AW:0]     len;
  logic            start, clear;
  logic            cm_valid;
  logic [XLEN-1:0] cm_pc, cm_wdata;
  logic [4:0]      cm_rd;
  logic            cm_wen;
  logic            core_en, busy, pass, fail;
  logic [2:0]      err_code;
  logic [AW:0]     err_idx;
  logic [CYCW-1:0] cycles;

  int n_checks = 0;
  int n_err    = 0;

  logic [XLEN-1:0] tr_pc [DEPTH];
  logic [4:0]      tr_rd [DEPTH];
  logic            tr_wen[DEPTH];
  logic [XLEN-1:0] tr_wd [DEPTH];

  typedef struct {
    logic [XLEN-1:0] epc;
    logic [4:0]      erd;
    logic            ewen;
    logic [XLEN-1:0] ewd;
    logic [XLEN-1:0] cpc;
    logic [4:0]      crd;
    logic            cwen;
    logic [XLEN-1:0] cwd;
    logic [2:0]      code;
  } vec_t;
  vec_t vecs[8];

  snurisc_trace_checker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO), .CYCW(CYCW)
  ) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_pc(ld_pc), .i_ld_wdata(ld_wdata),
    .i_ld_rd(ld_rd), .i_ld_wen(ld_wen), .i_len(len), .i_start(start), .i_clear(clear),
    .i_cm_valid(cm_valid), .i_cm_pc(cm_pc), .i_cm_wdata(cm_wdata), .i_cm_rd(cm_rd),
    .i_cm_wen(cm_wen),
    .o_core_en(core_en), .o_busy(busy), .o_pass(pass), .o_fail(fail),
    .o_err_code(err_code), .o_err_idx(err_idx), .o_cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [XLEN-1:0] pc, input logic [4:0] rd,
                      input logic wen, input logic [XLEN-1:0] wd);
    ld_we = 1'b1; ld_addr = AW'(a); ld_pc = pc; ld_rd = rd; ld_wen = wen; ld_wdata = wd;
    tr_pc[a] = pc; tr_rd[a] = rd; tr_wen[a] = wen; tr_wd[a] = wd;
    step();
    ld_we = 1'b0;
  endtask

  task automatic do_start(input int l);
    len = (AW+1)'(l); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic commit(input logic [XLEN-1:0] pc, input logic [4:0] rd,
                        input logic wen, input logic [XLEN-1:0] wd);
    cm_valid = 1'b1; cm_pc = pc; cm_rd = rd; cm_wen = wen; cm_wdata = wd;
    step();
    cm_valid = 1'b0;
  endtask

  task automatic commit_entry(input int i);
    commit(tr_pc[i], tr_rd[i], tr_wen[i], tr_wd[i]);
  endtask

  task automatic load_plan();
    for (int i = 0; i < 4; i++)
      load(i, XLEN'(4 * i), 5'(i + 1), 1'b1, XLEN'(17 * (i + 1)));
  endtask

  function automatic logic [2:0] ref_code(input int i, input logic [XLEN-1:0] pc,
      input logic [4:0] rd, input logic wen, input logic [XLEN-1:0] wd);
    if (pc != tr_pc[i]) return 3'd1;
    if (wen != tr_wen[i]) return 3'd2;
    if (tr_wen[i] && rd != tr_rd[i]) return 3'd2;
    if (tr_wen[i] && wd != tr_wd[i]) return 3'd3;
    return 3'd0;
  endfunction

  initial begin
    int          matched, gap, k, stall, l;
    bit          done, v, exp_pass;
    logic [2:0]  exp_code, c;
    int          exp_idx;
    logic [XLEN-1:0] rpc, rwd;
    logic [4:0]  rrd;
    logic        rwen;

    vecs[0] = '{32'h100, 5'd3, 1'b1, 32'hAA, 32'h100, 5'd3, 1'b1, 32'hAA, 3'd0};
    vecs[1] = '{32'h200, 5'd7, 1'b0, 32'h0,  32'h200, 5'd0, 1'b0, 32'hDEAD, 3'd0};
    vecs[2] = '{32'h200, 5'd7, 1'b0, 32'h0,  32'h200, 5'd7, 1'b1, 32'h0, 3'd2};
    vecs[3] = '{32'h300, 5'd5, 1'b1, 32'h55, 32'h304, 5'd6, 1'b0, 32'h56, 3'd1};
    vecs[4] = '{32'h300, 5'd5, 1'b1, 32'h55, 32'h300, 5'd6, 1'b1, 32'h56, 3'd2};
    vecs[5] = '{32'h300, 5'd5, 1'b1, 32'h55, 32'h300, 5'd5, 1'b1, 32'h56, 3'd3};
    vecs[6] = '{32'h300, 5'd5, 1'b1, 32'h55, 32'h300, 5'd5, 1'b0, 32'h55, 3'd2};
    vecs[7] = '{32'h400, 5'd0, 1'b1, 32'h0,  32'h400, 5'd0, 1'b1, 32'h1, 3'd3};

    rst_n = 1'b0; ld_we = 0; ld_addr = '0; ld_pc = '0; ld_wdata = '0; ld_rd = '0;
    ld_wen = 0; len = '0; start = 0; clear = 0; cm_valid = 0; cm_pc = '0;
    cm_wdata = '0; cm_rd = '0; cm_wen = 0;
    #12;
    check("rst_outputs", 64'({core_en, busy, pass, fail, err_code, err_idx, cycles}), 64'(0));
    #5 rst_n = 1'b1;
    step();

    // Compare-rule table, one-entry traces
    for (int t = 0; t < 8; t++) begin
      load(0, vecs[t].epc, vecs[t].erd, vecs[t].ewen, vecs[t].ewd);
      do_start(1);
      commit(vecs[t].cpc, vecs[t].crd, vecs[t].cwen, vecs[t].cwd);
      check($sformatf("vec%0d_pass", t), 64'(pass), 64'(vecs[t].code == 3'd0));
      check($sformatf("vec%0d_fail", t), 64'(fail), 64'(vecs[t].code != 3'd0));
      check($sformatf("vec%0d_code", t), 64'(err_code), 64'(vecs[t].code));
      check($sformatf("vec%0d_core_en", t), 64'(core_en), 64'(0));
      do_clear();
    end

    // Four matching back-to-back commits
    load_plan();
    do_start(4);
    check("p1_core_en_on", 64'(core_en), 64'(1));
    check("p1_busy_on", 64'(busy), 64'(1));
    for (int i = 0; i < 3; i++) commit_entry(i);
    check("p1_not_yet", 64'(pass), 64'(0));
    commit_entry(3);
    check("p1_pass", 64'(pass), 64'(1));
    check("p1_core_en_off", 64'(core_en), 64'(0));
    check("p1_code", 64'(err_code), 64'(0));
    check("p1_cycles", 64'(cycles), 64'(4));
    do_clear();
    check("p1_cleared", 64'({pass, fail, busy}), 64'(0));

    // wdata mismatch on 3rd commit; a later commit is ignored
    do_start(4);
    commit_entry(0);
    commit_entry(1);
    commit(tr_pc[2], tr_rd[2], 1'b1, 32'h34);
    check("p2_fail", 64'(fail), 64'(1));
    check("p2_code", 64'(err_code), 64'(3));
    check("p2_idx", 64'(err_idx), 64'(2));
    commit_entry(3);
    check("p2_hold", 64'({pass, fail, core_en, err_code, err_idx, cycles}),
          64'({1'b0, 1'b1, 1'b0, 3'd3, 5'd2, 6'd3}));
    do_clear();

    // Timeout with no commits
    do_start(4);
    for (int i = 0; i < 15; i++) step();
    check("to_15_no_fail", 64'({fail, core_en}), 64'({1'b0, 1'b1}));
    step();
    check("to_fail", 64'(fail), 64'(1));
    check("to_code", 64'(err_code), 64'(4));
    check("to_idx", 64'(err_idx), 64'(0));
    check("to_cycles", 64'(cycles), 64'(16));
    do_clear();

    // Commit on the 16th cycle beats the timeout
    do_start(4);
    for (int i = 0; i < 15; i++) step();
    commit_entry(0);
    check("to_rescue", 64'({fail, core_en}), 64'({1'b0, 1'b1}));
    for (int i = 1; i < 4; i++) commit_entry(i);
    check("to_rescue_pass", 64'(pass), 64'(1));
    do_clear();

    // Empty trace
    do_start(0);
    check("len0_pass", 64'({pass, core_en, cycles}), 64'({1'b1, 1'b0, 6'd0}));
    do_clear();
    check("len0_idle", 64'({pass, busy}), 64'(0));
    do_start(4);
    for (int i = 0; i < 4; i++) commit_entry(i);
    check("len0_restart_pass", 64'(pass), 64'(1));
    do_clear();

    // Asynchronous reset mid-run
    do_start(4);
    commit_entry(0);
    commit_entry(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", 64'({core_en, busy, pass, fail, err_code, err_idx, cycles}), 64'(0));
    #2 rst_n = 1'b1;
    step();
    do_start(4);
    for (int i = 0; i < 4; i++) commit_entry(i);
    check("arst_restart_pass", 64'({pass, err_idx, cycles}), 64'({1'b1, 5'd0, 6'd4}));
    do_clear();

    // Randomized runs against the commit-level reference model
    for (int it = 0; it < 40; it++) begin
      l = $urandom_range(0, DEPTH);
      for (int e = 0; e < l; e++)
        load(e, $urandom, 5'($urandom), 1'($urandom), $urandom);
      do_start(l);
      matched = 0; gap = 0; k = 0; stall = 0;
      done = 0; exp_pass = 0; exp_code = 3'd0; exp_idx = 0;
      if (l == 0) begin
        done = 1; exp_pass = 1;
      end
      while (!done) begin
        k++;
        if (stall == 0 && $urandom_range(0, 99) < 3) stall = TMO + 4;
        if (stall > 0) begin
          v = 0; stall--;
        end else begin
          v = ($urandom_range(0, 99) < 75);
        end
        rpc = tr_pc[matched]; rrd = tr_rd[matched]; rwen = tr_wen[matched]; rwd = tr_wd[matched];
        case ($urandom_range(0, 24))
          0: rpc = rpc ^ (XLEN'(1) << $urandom_range(0, XLEN - 1));
          1: rrd = rrd ^ 5'($urandom_range(1, 31));
          2: rwen = ~rwen;
          3: rwd = rwd ^ (XLEN'(1) << $urandom_range(0, XLEN - 1));
          default: ;
        endcase
        if (v) begin
          c = ref_code(matched, rpc, rrd, rwen, rwd);
          gap = 0;
          if (c != 3'd0) begin
            done = 1; exp_code = c; exp_idx = matched;
          end else begin
            matched++;
            if (matched == l) begin
              done = 1; exp_pass = 1;
            end
          end
        end else begin
          gap++;
          if (gap == TMO) begin
            done = 1; exp_code = 3'd4; exp_idx = matched;
          end
        end
        cm_valid = v; cm_pc = rpc; cm_rd = rrd; cm_wen = rwen; cm_wdata = rwd;
        step();
        cm_valid = 1'b0;
        check("rnd_core_en", 64'(core_en), 64'(!done));
      end
      check("rnd_pass", 64'(pass), 64'(exp_pass));
      check("rnd_fail", 64'(fail), 64'(!exp_pass));
      check("rnd_code", 64'(err_code), 64'(exp_code));
      check("rnd_idx", 64'(err_idx), 64'(exp_idx));
      check("rnd_cycles", 64'(cycles), 64'((k > 63) ? 63 : k));
      do_clear();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
